// File: rtl/error_tolerant_type2_adder_seq_if.sv
// ---------------------------------------------------------------------------
// Module  : error_tolerant_type2_adder_seq_if
// Brief   : Operand/result handshake bundle for the segmented type-II adder.
//           err_cnt_o is present only when ERR_COUNT_EN is defined.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface error_tolerant_type2_adder_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic             exact_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH:0]   result_o;
  logic             err_o;
`ifdef ERR_COUNT_EN
  logic [15:0]      err_cnt_o;
`endif

  modport master (
`ifdef ERR_COUNT_EN
    input  err_cnt_o,
`endif
    output in_valid_i, add1_i, add2_i, exact_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, err_o
  );

  modport slave (
`ifdef ERR_COUNT_EN
    output err_cnt_o,
`endif
    input  in_valid_i, add1_i, add2_i, exact_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/error_tolerant_type2_adder_seq.sv
// ---------------------------------------------------------------------------
// Module  : error_tolerant_type2_adder_seq
// Brief   : Registered type-II error-tolerant segmented adder with valid/ready
//           handshake and optional one-cycle exact correction.
//           Optional feature macro: ERR_COUNT_EN (saturating error counter).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module error_tolerant_type2_adder_seq #(
  parameter int WIDTH = 16,
  parameter int SEGW  = 4
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_i,
  error_tolerant_type2_adder_seq_if.slave bus
);
  localparam int NSEG = WIDTH / SEGW;

  if ((WIDTH % SEGW) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of SEGW");
  end

  typedef enum logic [1:0] {S_IDLE, S_SPEC, S_CORR, S_OUT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_exact;
  logic [WIDTH:0]   r_result;
  logic             r_err;
  logic             r_out_valid;

  logic [NSEG-1:0][SEGW:0] w_pair;
  logic [NSEG-1:0]         w_spec_cin;
  logic [NSEG-1:0]         w_true_cin;
  logic [WIDTH-1:0]        w_spec_sum;
  logic                    w_spec_cout;
  logic [WIDTH:0]          w_exact;
  logic                    w_err;
  logic                    w_accept;
  logic                    w_correct;

  assign w_exact = {1'b0, r_a} + {1'b0, r_b};

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign w_pair[k] = {1'b0, r_a[k*SEGW +: SEGW]} + {1'b0, r_b[k*SEGW +: SEGW]};

    if (k == 0) begin : g_lsb
      assign w_spec_cin[k] = 1'b0;
      assign w_true_cin[k] = 1'b0;
    end else begin : g_upper
      // Speculation looks back exactly one segment, ignoring its own carry-in.
      assign w_spec_cin[k] = w_pair[k-1][SEGW];
      assign w_true_cin[k] = w_exact[k*SEGW] ^ r_a[k*SEGW] ^ r_b[k*SEGW];
    end

    if (k == NSEG - 1) begin : g_top
      assign {w_spec_cout, w_spec_sum[k*SEGW +: SEGW]} =
        w_pair[k] + {{SEGW{1'b0}}, w_spec_cin[k]};
    end else begin : g_mid
      assign w_spec_sum[k*SEGW +: SEGW] =
        w_pair[k][SEGW-1:0] + {{(SEGW-1){1'b0}}, w_spec_cin[k]};
    end
  end

  assign w_err     = |(w_spec_cin ^ w_true_cin);
  assign w_correct = r_exact & w_err;

  assign bus.in_ready_o  = (r_state == S_IDLE) | ((r_state == S_OUT) & bus.out_ready_i);
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.err_o       = r_err;
  assign w_accept        = bus.in_valid_i & bus.in_ready_o;

`ifdef ERR_COUNT_EN
  logic [15:0] r_err_cnt;
  assign bus.err_cnt_o = r_err_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_exact     <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ERR_COUNT_EN
      r_err_cnt   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_a     <= bus.add1_i;
        r_b     <= bus.add2_i;
        r_exact <= bus.exact_i;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_SPEC;
        end
        S_SPEC: begin
          r_result    <= {w_spec_cout, w_spec_sum};
          r_err       <= w_err;
          r_out_valid <= ~w_correct;
          r_state     <= w_correct ? S_CORR : S_OUT;
        end
        S_CORR: begin
          r_result    <= w_exact;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_state     <= w_accept ? S_SPEC : S_IDLE;
`ifdef ERR_COUNT_EN
            if (r_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_error_tolerant_type2_adder_seq.sv
// ---------------------------------------------------------------------------
// Module  : tb_error_tolerant_type2_adder_seq
// Brief   : Directed and random operations against a segment-arithmetic model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_error_tolerant_type2_adder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  error_tolerant_type2_adder_seq_if #(.WIDTH(16)) bus ();

  error_tolerant_type2_adder_seq #(.WIDTH(16), .SEGW(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   first    = 1'b1;
  bit   rnd_rdy  = 1'b0;
  bit   rdy_force = 1'b1;
  logic [15:0] mcnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Returns {err, result}; result is exact only when correction is requested.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic ex);
    int exact, approx, cin, s, ak, bk;
    logic err;
    exact  = int'(a) + int'(b);
    approx = 0;
    for (int k = 0; k < 4; k++) begin
      ak = (int'(a) >> (4*k)) & 15;
      bk = (int'(b) >> (4*k)) & 15;
      cin = (k == 0) ? 0 :
            ((((int'(a) >> (4*(k-1))) & 15) + ((int'(b) >> (4*(k-1))) & 15)) >> 4);
      s = ak + bk + cin;
      approx = approx | ((s & 15) << (4*k));
      if (k == 3) approx = approx | ((s >> 4) << 16);
    end
    err = (approx != exact);
    return {err, (ex && err) ? exact[16:0] : approx[16:0]};
  endfunction

  always @(posedge clk) begin
    #2;
    bus.out_ready_i = rnd_rdy ? (($urandom % 4) != 0) : rdy_force;
  end

  always @(negedge clk) begin
    logic [17:0] m;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      first = 1'b1;
      mcnt  = '0;
    end else begin
`ifdef ERR_COUNT_EN
      chk("err_cnt", {16'h0, bus.err_cnt_o}, {16'h0, mcnt});
`endif
      if (bus.out_valid_o) begin
        if (q.size() == 0) begin
          chk("valid_without_pending", {31'h0, bus.out_valid_o}, 32'h0);
        end else begin
          chk("result", {15'h0, bus.result_o}, {15'h0, q[0].res});
          chk("err", {31'h0, bus.err_o}, {31'h0, q[0].err});
          chk("in_ready_in_out", {31'h0, bus.in_ready_o}, {31'h0, bus.out_ready_i});
          if (first) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            first = 1'b0;
          end
          if (bus.out_ready_i) begin
`ifdef ERR_COUNT_EN
            if (q[0].err && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
`endif
            void'(q.pop_front());
            first = 1'b1;
          end
        end
      end else begin
        chk("in_ready_busy", {31'h0, bus.in_ready_o}, {31'h0, (q.size() == 0)});
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        m = model(bus.add1_i, bus.add2_i, bus.exact_i);
        e.res = m[16:0];
        e.err = m[17];
        e.lat = (bus.exact_i && m[17]) ? 3 : 2;
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ex, output int tries);
    bit acc;
    bus.in_valid_i = 1'b1;
    bus.add1_i     = a;
    bus.add2_i     = b;
    bus.exact_i    = ex;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      tries++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(input logic [16:0] res, input logic err);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid_o) begin
        seen = 1'b1;
        chk("dir_result", {15'h0, bus.result_o}, {15'h0, res});
        chk("dir_err", {31'h0, bus.err_o}, {31'h0, err});
      end
    end
    if (!seen) chk("out_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic [15:0] a, b;
    bus.in_valid_i = 1'b0;
    bus.add1_i     = '0;
    bus.add2_i     = '0;
    bus.exact_i    = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
    chk("rst_in_ready", {31'h0, bus.in_ready_o}, 32'h1);
    chk("rst_result", {15'h0, bus.result_o}, 32'h0);
    chk("rst_err", {31'h0, bus.err_o}, 32'h0);

    chk("model_v1", {14'h0, model(16'h1234, 16'h1111, 1'b0)}, {14'h0, 18'h02345});
    chk("model_v2a", {14'h0, model(16'h00FF, 16'h0001, 1'b0)}, {14'h0, 18'h20000});
    chk("model_v2e", {14'h0, model(16'h00FF, 16'h0001, 1'b1)}, {14'h0, 18'h20100});
    chk("model_v3e", {14'h0, model(16'hFFFF, 16'h0001, 1'b1)}, {14'h0, 18'h30000});
    // Segment 2 sees no carry from segment 1's operands alone, so upper bits stay F.
    chk("model_v3a", {14'h0, model(16'hFFFF, 16'h0001, 1'b0)}, {14'h0, 18'h2FF00});

    send(16'h1234, 16'h1111, 1'b0, t); wait_out(17'h02345, 1'b0);
    send(16'h00FF, 16'h0001, 1'b0, t); wait_out(17'h00000, 1'b1);
    send(16'h00FF, 16'h0001, 1'b1, t); wait_out(17'h00100, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b1, t); wait_out(17'h10000, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0, t); wait_out(17'h0FF00, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    rdy_force = 1'b0;
    repeat (1) @(posedge clk);
    #1;
    send(16'hABCD, 16'h0123, 1'b0, t);
    repeat (8) @(posedge clk);
    #1;
    rdy_force = 1'b1;
    send(16'h0F0F, 16'h0101, 1'b1, t);
    chk("handoff_accept_tries", t, 1);
    repeat (4) @(posedge clk);
    #1;

    send(16'h00FF, 16'h0001, 1'b1, t);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
    chk("abort_in_ready", {31'h0, bus.in_ready_o}, 32'h1);
    chk("abort_result", {15'h0, bus.result_o}, 32'h0);
    repeat (5) @(posedge clk);
    #1;

`ifdef ERR_COUNT_EN
    for (int i = 0; i < 3; i++) begin
      send(16'h00FF, 16'h0001, i[0], t);
      wait_out(i[0] ? 17'h00100 : 17'h00000, 1'b1);
    end
    send(16'h1234, 16'h1111, 1'b0, t); wait_out(17'h02345, 1'b0);
    @(negedge clk);
    chk("err_cnt_three", {16'h0, bus.err_cnt_o}, 32'd3);
    @(posedge clk);
    #1;
`endif

    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom % 4)
        0: begin a = 16'($urandom); b = 16'($urandom); end
        1: begin a = 16'($urandom) | 16'h0F0F; b = 16'($urandom_range(0, 15)); end
        2: begin a = 16'hFFFF ^ (16'h1 << $urandom_range(0, 15)); b = 16'($urandom_range(1, 3)); end
        default: begin a = 16'($urandom) & 16'h7777; b = 16'($urandom) & 16'h7777; end
      endcase
      send(a, b, 1'($urandom), t);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    rnd_rdy   = 1'b0;
    rdy_force = 1'b1;
    for (int i = 0; i < 50 && (q.size() != 0 || bus.out_valid_o); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

`default_nettype wire
